nav_spi_responder: RTL and testbench

NAV_SPI_RESPONDER -- requirements
Module: nav_spi_responder

---
 rtl/nav_spi_responder.sv | 151 +++++++++++++++
 tb/tb_nav_spi_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nav_spi_responder.sv
// rtl/nav_spi_responder.sv - SPI mode-3 register responder with WHO_AM_I and 16-byte storage
// Oversampled SPI slave: synchronized pins, edge detect, auto-incrementing burst reads/writes.
module nav_spi_responder #(
  parameter logic [7:0] WHOAMI_VAL  = 8'h68,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       s00_axi_aclk,
  input  logic       s00_axi_aresetn,
  input  logic       spi_cs_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       reg_wr_valid,
  output logic [6:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CMD, RD, WR} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, mosi_sync;
  logic       cs_q, sclk_q;
  logic       cs_s, sclk_s, mosi_s;
  logic       cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic [2:0] bit_cnt;
  logic [6:0] shift_in;
  logic [6:0] shift_out;
  logic [6:0] addr;
  logic       miso_bit;
  logic       oe_en;
  logic [7:0] rd_data;
  logic [7:0] wr_byte;
  logic [7:0] mem [16];

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      mosi_sync <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_q      <= cs_s;
      sclk_q    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_q & ~cs_s;
  assign cs_rise   = ~cs_q & cs_s;
  assign sclk_rise = ~sclk_q & sclk_s;
  assign sclk_fall = sclk_q & ~sclk_s;
  assign wr_byte   = {shift_in, mosi_s};

  always_comb begin
    rd_data = 8'h00;
    if (addr == 7'h0F)
      rd_data = WHOAMI_VAL;
    else if (addr[6:4] == 3'b001)
      rd_data = mem[addr[3:0]];
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= IDLE;
    else                  state <= state_nxt;
  end

  // A cs_n rise outranks any sclk edge seen in the same cycle.
  always_comb begin
    state_nxt = state;
    if (state == IDLE) begin
      if (cs_fall) state_nxt = CMD;
    end else if (cs_rise) begin
      state_nxt = IDLE;
    end else if (state == CMD && sclk_rise && bit_cnt == 3'd7) begin
      state_nxt = shift_in[6] ? RD : WR;
    end
  end

  always_comb begin
    busy        = (state != IDLE);
    spi_miso_oe = (state == RD) && oe_en;
    spi_miso    = spi_miso_oe & miso_bit;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      bit_cnt      <= 3'd0;
      shift_in     <= 7'd0;
      shift_out    <= 7'd0;
      addr         <= 7'd0;
      miso_bit     <= 1'b0;
      oe_en        <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= 7'd0;
      reg_wr_data  <= 8'd0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
    end else begin
      reg_wr_valid <= 1'b0;
      if (state == IDLE) begin
        if (cs_fall) begin
          bit_cnt  <= 3'd0;
          oe_en    <= 1'b0;
          miso_bit <= 1'b0;
        end
      end else if (!cs_rise) begin
        case (state)
          CMD: if (sclk_rise) begin
            shift_in <= wr_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) addr <= wr_byte[6:0];
          end
          // bit_cnt==0 on a fall marks the first bit of a byte: fetch addr fresh.
          RD: if (sclk_fall) begin
            oe_en <= 1'b1;
            if (bit_cnt == 3'd0) begin
              miso_bit  <= rd_data[7];
              shift_out <= rd_data[6:0];
            end else begin
              miso_bit  <= shift_out[6];
              shift_out <= {shift_out[5:0], 1'b0};
            end
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) addr <= addr + 7'd1;
          end
          WR: if (sclk_rise) begin
            shift_in <= wr_byte[6:0];
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr[6:4] == 3'b001) mem[addr[3:0]] <= wr_byte;
              reg_wr_valid <= 1'b1;
              reg_wr_addr  <= addr;
              reg_wr_data  <= wr_byte;
              addr         <= addr + 7'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nav_spi_responder.sv
// tb/tb_nav_spi_responder.sv - directed and randomized bench for nav_spi_responder
// Bit-banged SPI master against a register-map model of storage, WHO_AM_I and write pulses.
module tb_nav_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic       sclk = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, wr_valid, busy;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  int nchk = 0;
  int nerr = 0;

  logic [7:0]  model [16];
  logic [14:0] got_q[$];
  logic [14:0] exp_q[$];

  nav_spi_responder dut (
    .s00_axi_aclk   (clk),
    .s00_axi_aresetn(rst_n),
    .spi_cs_n       (cs_n),
    .spi_sclk       (sclk),
    .spi_mosi       (mosi),
    .spi_miso       (miso),
    .spi_miso_oe    (miso_oe),
    .reg_wr_valid   (wr_valid),
    .reg_wr_addr    (wr_addr),
    .reg_wr_data    (wr_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_valid) got_q.push_back({wr_addr, wr_data});

  initial begin
    #900000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] model_rd(input logic [6:0] a);
    if (a == 7'h0F) return 8'h68;
    if (a >= 7'h10 && a <= 7'h1F) return model[a - 7'h10];
    return 8'h00;
  endfunction

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input int half,
                          output logic [7:0] rx, output bit oe_all, output bit oe_any);
    rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1'b0;
      mosi = tx[7-i];
      idle_cycles(half);
      sclk = 1'b1;
      rx = {rx[6:0], miso};
      oe_all &= miso_oe;
      oe_any |= miso_oe;
      idle_cycles(half);
    end
  endtask

  task automatic start_xfer();
    cs_n = 1'b0;
    idle_cycles(4);
    chk("busy_active", busy, 1'b1);
  endtask

  task automatic stop_xfer();
    cs_n = 1'b1;
    idle_cycles(4);
    chk("busy_idle", busy, 1'b0);
    chk("oe_idle", miso_oe, 1'b0);
    idle_cycles(2);
  endtask

  task automatic check_pulses(input string tag);
    chk({tag, "_pulse_cnt"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({tag, "_pulse"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic write_burst(input logic [6:0] a0, input logic [7:0] d[$], input int half);
    logic [7:0] rx;
    bit oa, on;
    logic [6:0] a;
    a = a0;
    start_xfer();
    spi_bits({1'b0, a0}, 8, half, rx, oa, on);
    foreach (d[i]) begin
      spi_bits(d[i], 8, half, rx, oa, on);
      chk("wr_oe_low", on, 1'b0);
      exp_q.push_back({a, d[i]});
      if (a >= 7'h10 && a <= 7'h1F) model[a - 7'h10] = d[i];
      a = a + 7'd1;
    end
    stop_xfer();
    check_pulses("wr");
  endtask

  task automatic read_burst(input logic [6:0] a0, input int n, input int half);
    logic [7:0] rx;
    bit oa, on;
    logic [6:0] a;
    a = a0;
    start_xfer();
    spi_bits({1'b1, a0}, 8, half, rx, oa, on);
    chk("cmd_oe_low", on, 1'b0);
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, half, rx, oa, on);
      chk("rd_data", rx, model_rd(a));
      chk("rd_oe_high", oa, 1'b1);
      a = a + 7'd1;
    end
    stop_xfer();
    check_pulses("rd");
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] d[$];
    bit oa, on;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    idle_cycles(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_oe", miso_oe, 1'b0);
    chk("rst_miso", miso, 1'b0);
    chk("rst_wr_valid", wr_valid, 1'b0);
    chk("rst_wr_addr", wr_addr, 7'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    rst_n = 1'b1;
    idle_cycles(3);

    read_burst(7'h0F, 1, 8);
    d = '{8'hA5, 8'h3C};
    write_burst(7'h10, d, 8);
    read_burst(7'h10, 2, 8);

    d = '{8'h11, 8'h22};
    write_burst(7'h7F, d, 8);
    read_burst(7'h1F, 2, 8);

    // Partial trailing byte must be dropped.
    start_xfer();
    spi_bits(8'h12, 8, 8, rx, oa, on);
    spi_bits(8'h55, 8, 8, rx, oa, on);
    exp_q.push_back({7'h12, 8'h55});
    model[2] = 8'h55;
    spi_bits(8'hFF, 5, 8, rx, oa, on);
    cs_n = 1'b1;
    idle_cycles(4);
    chk("partial_busy", busy, 1'b0);
    idle_cycles(4);
    check_pulses("partial");
    read_burst(7'h12, 2, 8);

    d = '{8'h5A, 8'hC3};
    write_burst(7'h10, d, 4);
    read_burst(7'h0F, 1, 4);
    read_burst(7'h10, 2, 4);

    for (int it = 0; it < 24; it++) begin
      int half, n;
      logic [6:0] a;
      half = ($urandom_range(0, 1) == 0) ? 4 : 8;
      n = $urandom_range(1, 4);
      a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(8'h0C, 8'h22));
      if ($urandom_range(0, 1) == 0) begin
        d.delete();
        for (int k = 0; k < n; k++) d.push_back(8'($urandom));
        write_burst(a, d, half);
      end else begin
        read_burst(a, n, half);
      end
    end

    // Reset in the middle of the 4th data bit of a WHO_AM_I read.
    start_xfer();
    spi_bits(8'h8F, 8, 8, rx, oa, on);
    spi_bits(8'h00, 3, 8, rx, oa, on);
    chk("midrd_oe_before", miso_oe, 1'b1);
    chk("midrd_partial", rx[2:0], 3'b011);
    sclk = 1'b0;
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    chk("midrd_oe_reset", miso_oe, 1'b0);
    chk("midrd_busy_reset", busy, 1'b0);
    chk("midrd_miso_reset", miso, 1'b0);
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    cs_n = 1'b1;
    sclk = 1'b1;
    idle_cycles(3);
    rst_n = 1'b1;
    idle_cycles(4);
    chk("midrd_busy_after", busy, 1'b0);
    check_pulses("midrd");
    read_burst(7'h0F, 1, 8);
    read_burst(7'h10, 3, 8);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
